// File: rtl/logic_cell_pkg.sv
// logic_cell_pkg: shared defaults, the LUT config word type and a majority helper.
package logic_cell_pkg;

    localparam int LUT_K_DEF     = 4;
    localparam int CNT_WIDTH_DEF = 5;
    localparam int LUT_CFG_W     = 2 ** LUT_K_DEF;

    // Truth-table word for a default-sized LUT.
    typedef logic [LUT_CFG_W-1:0] lut_cfg_t;

    // Carry of a full adder: true when at least two inputs are high.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : logic_cell_pkg

// File: rtl/logic_cell_lut.sv
// logic_cell_lut: K-input look-up table with MSB-first indexing.
// sel = all-ones picks cfg[0], sel = all-zeros picks cfg[2**K-1].
module logic_cell_lut
    import logic_cell_pkg::*;
#(
    parameter int K = LUT_K_DEF
) (
    input  logic [2**K-1:0] cfg,
    input  logic [K-1:0]    sel,
    output logic            out
);

    logic [K-1:0] idx;

    // Select the truth-table bit; (2**K-1) - sel is simply ~sel for a K-bit sel.
    always_comb begin
        idx = ~sel;
        out = cfg[idx];
    end

endmodule : logic_cell_lut

// File: rtl/logic_cell.sv
// logic_cell: K-input LUT, 1-bit full adder and a free-running LED counter.
// Optional build macro LOGIC_CELL_OUT_REG_EN registers lut_out, sum_out and
// carry_out (1-cycle latency, cleared by rst). Without it they are combinational.
module logic_cell
    import logic_cell_pkg::*;
#(
    parameter int LUT_K     = LUT_K_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**LUT_K-1:0]   lut_config,
    input  logic [LUT_K-1:0]      lut_inputs,
    output logic                  lut_out,
    input  logic                  carry_in,
    input  logic                  data_0,
    input  logic                  data_1,
    output logic                  sum_out,
    output logic                  carry_out,
    output logic [CNT_WIDTH-1:0]  leds
);

    logic lut_comb;
    logic sum_comb;
    logic carry_comb;

    logic_cell_lut #(
        .K (LUT_K)
    ) u_lut (
        .cfg (lut_config),
        .sel (lut_inputs),
        .out (lut_comb)
    );

    // Full adder: parity for the sum, majority for the carry.
    always_comb begin
        sum_comb   = data_0 ^ data_1 ^ carry_in;
        carry_comb = maj3(data_0, data_1, carry_in);
    end

    logic [CNT_WIDTH-1:0] leds_d;
    logic [CNT_WIDTH-1:0] leds_q;

    // Counter next value; the natural overflow of the add gives the wrap to 0.
    always_comb begin
        leds_d = leds_q + CNT_WIDTH'(1);
    end

    // Counter register; synchronous rst wins over the increment.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds = leds_q;

`ifdef LOGIC_CELL_OUT_REG_EN
    logic lut_d,   lut_q;
    logic sum_d,   sum_q;
    logic carry_d, carry_q;

    // Next values for the output registers are the combinational results.
    always_comb begin
        lut_d   = lut_comb;
        sum_d   = sum_comb;
        carry_d = carry_comb;
    end

    // Output registers: capture on every edge, cleared by synchronous rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_q   <= 1'b0;
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            lut_q   <= lut_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign lut_out   = lut_q;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;
`else
    assign lut_out   = lut_comb;
    assign sum_out   = sum_comb;
    assign carry_out = carry_comb;
`endif

endmodule : logic_cell

// File: tb/tb_logic_cell.sv
// tb_logic_cell: scoreboard bench for logic_cell. Stimulus pushes expected
// responses tagged with the cycle they become visible; a monitor on the
// falling edge pops and compares them. Follows LOGIC_CELL_OUT_REG_EN.
module tb_logic_cell;
    import logic_cell_pkg::*;

`ifdef LOGIC_CELL_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    // Adder truth tables indexed by {data_0, data_1, carry_in}.
    localparam logic [7:0] SUM_TBL   = 8'b1001_0110;
    localparam logic [7:0] CARRY_TBL = 8'b1110_1000;

    logic        clk = 1'b0;
    logic        rst;
    lut_cfg_t    lut_config;
    logic [3:0]  lut_inputs;
    logic        lut_out;
    logic        carry_in;
    logic        data_0;
    logic        data_1;
    logic        sum_out;
    logic        carry_out;
    logic [4:0]  leds;

    logic_cell dut (
        .clk        (clk),
        .rst        (rst),
        .lut_config (lut_config),
        .lut_inputs (lut_inputs),
        .lut_out    (lut_out),
        .carry_in   (carry_in),
        .data_0     (data_0),
        .data_1     (data_1),
        .sum_out    (sum_out),
        .carry_out  (carry_out),
        .leds       (leds)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_leds;
        logic       lut;
        logic       sum;
        logic       carry;
        logic [4:0] leds;
        int         due;
        string      name;
        int         tag;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   checks   = 0;
    int   failures = 0;

    // Monitor: compare every expectation whose visibility cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            m = sb.pop_front();
            checks++;
            if (m.is_leds) begin
                if (leds !== m.leds) begin
                    failures++;
                    $display("FAIL %s #%0d: leds got %0d want %0d", m.name, m.tag, leds, m.leds);
                end
            end else if ({lut_out, sum_out, carry_out} !== {m.lut, m.sum, m.carry}) begin
                failures++;
                $display("FAIL %s #%0d: got lut=%b sum=%b carry=%b want lut=%b sum=%b carry=%b",
                         m.name, m.tag, lut_out, sum_out, carry_out, m.lut, m.sum, m.carry);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected responses.
    task automatic apply(input string name, input int tag, input lut_cfg_t cfg,
                         input logic [3:0] sel, input logic [2:0] add, input logic r,
                         input logic exp_lut, input bit chk_leds, input logic [4:0] exp_leds);
        exp_t e;
        lut_config = cfg;
        lut_inputs = sel;
        {data_0, data_1, carry_in} = add;
        rst = r;
        e.is_leds = 1'b0;
        e.lut     = exp_lut;
        e.sum     = SUM_TBL[add];
        e.carry   = CARRY_TBL[add];
        e.leds    = '0;
        e.due     = cyc + LAT;
        e.name    = name;
        e.tag     = tag;
`ifdef LOGIC_CELL_OUT_REG_EN
        if (r) {e.lut, e.sum, e.carry} = 3'b000;
`endif
        sb.push_back(e);
        if (chk_leds) begin
            e.is_leds = 1'b1;
            e.leds    = exp_leds;
            e.due     = cyc + 1;
            e.name    = {name, "_leds"};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        lut_config = 16'hFFFF;
        lut_inputs = 4'h0;
        {data_0, data_1, carry_in} = 3'b110;
        @(posedge clk);
        #1;

        // Counter: two reset edges, full wrap, count to 17, reset mid-count, resume.
        apply("rst_hold", 0, 16'hFFFF, 4'h0, 3'b110, 1'b1, 1'b1, 1'b1, 5'd0);
        apply("rst_hold", 1, 16'hFFFF, 4'h0, 3'b110, 1'b1, 1'b1, 1'b1, 5'd0);
        for (int i = 1; i <= 32; i++)
            apply("count_wrap", i, 16'hFFFF, 4'h0, 3'b110, 1'b0, 1'b1, 1'b1, 5'(i));
        for (int i = 1; i <= 17; i++)
            apply("count_17", i, 16'hFFFF, 4'h0, 3'b110, 1'b0, 1'b1, 1'b1, 5'(i));
        apply("rst_mid", 0, 16'hFFFF, 4'h0, 3'b110, 1'b1, 1'b1, 1'b1, 5'd0);
        apply("resume", 0, 16'hFFFF, 4'h0, 3'b110, 1'b0, 1'b1, 1'b1, 5'd1);

        // LUT sweeps; the adder operands walk all 8 combinations alongside.
        for (int i = 0; i < 16; i++)
            apply("lut_0000", i, 16'h0000, 4'(i), 3'(i), 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 16; i++)
            apply("lut_0001", i, 16'h0001, 4'(i), 3'(i), 1'b0, (i == 15), 1'b0, 5'd0);
        for (int i = 0; i < 16; i++)
            apply("lut_8000", i, 16'h8000, 4'(i), 3'(15 - i), 1'b0, (i == 0), 1'b0, 5'd0);
        for (int i = 0; i < 16; i++)
            apply("lut_6996", i, 16'h6996, 4'(i), 3'(i + 3), 1'b0, ^4'(i), 1'b0, 5'd0);

        // Asymmetric pattern 16'h1234: ones at bits 12, 9, 5, 4, 2.
        apply("lut_1234", 0,  16'h1234, 4'd0,  3'b111, 1'b0, 1'b0, 1'b0, 5'd0);
        apply("lut_1234", 3,  16'h1234, 4'd3,  3'b100, 1'b0, 1'b1, 1'b0, 5'd0);
        apply("lut_1234", 4,  16'h1234, 4'd4,  3'b011, 1'b0, 1'b0, 1'b0, 5'd0);
        apply("lut_1234", 6,  16'h1234, 4'd6,  3'b001, 1'b0, 1'b1, 1'b0, 5'd0);
        apply("lut_1234", 10, 16'h1234, 4'd10, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
        apply("lut_1234", 13, 16'h1234, 4'd13, 3'b101, 1'b0, 1'b1, 1'b0, 5'd0);
        apply("lut_1234", 15, 16'h1234, 4'd15, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);

        // Reset with a nonzero result on the inputs: registered outputs clear,
        // combinational ones are untouched; counter restarts.
        apply("rst_outs", 0, 16'hFFFF, 4'h5, 3'b111, 1'b1, 1'b1, 1'b1, 5'd0);
        apply("rst_outs", 1, 16'hFFFF, 4'h5, 3'b111, 1'b0, 1'b1, 1'b1, 5'd1);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_logic_cell
